// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the IF-stage controller (master) and the PC generator (slave).
interface pc_gen_if #(
  parameter int XLEN = 32
);

  logic            start_i;
  logic            halt_i;
  logic            pc_write_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            trap_i;
  logic            call_i;
  logic            ret_i;
  logic [XLEN-1:0] pc_o;
  logic            pc_valid_o;
  logic            ras_empty_o;
  logic            ras_full_o;
  logic [1:0]      state_o;

  modport master (
    output start_i, halt_i, pc_write_i, redirect_i, redirect_pc_i,
    output trap_i, call_i, ret_i,
    input  pc_o, pc_valid_o, ras_empty_o, ras_full_o, state_o
  );

  modport slave (
    input  start_i, halt_i, pc_write_i, redirect_i, redirect_pc_i,
    input  trap_i, call_i, ret_i,
    output pc_o, pc_valid_o, ras_empty_o, ras_full_o, state_o
  );

endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: IDLE/RUN/HALT run control, prioritised next-PC
// selection and a circular return-address stack for call/return prediction.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  pc_gen_if.slave  bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, pc_inc;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
  logic              ras_we;
  logic [PTR_W-1:0]  ras_waddr;
  logic              ras_empty, ras_full;

  assign pc_inc    = pc_q + XLEN'(INC);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
      top_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stack contents need no reset: a zero count makes every entry unreachable.
  always_ff @(posedge clk_i) begin
    if (ras_we) begin
      ras_mem[ras_waddr] <= pc_inc;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = top_q;

    case (state_q)
      IDLE: begin
        pc_d = RESET_VEC;
        if (bus.start_i) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.trap_i) begin
          pc_d  = TRAP_VEC;
          cnt_d = '0;
        end else if (bus.halt_i) begin
          state_d = HALT;
        end else if (bus.redirect_i) begin
          pc_d = bus.redirect_pc_i;
        end else if (bus.pc_write_i) begin
          if (bus.ret_i && !ras_empty) begin
            pc_d = ras_mem[top_q];
            // A call paired with a return rewrites the popped slot in place.
            if (bus.call_i) begin
              ras_we    = 1'b1;
              ras_waddr = top_q;
            end else begin
              top_d = top_q - PTR_W'(1);
              cnt_d = cnt_q - CNT_W'(1);
            end
          end else begin
            pc_d = pc_inc;
            if (bus.call_i) begin
              ras_we    = 1'b1;
              ras_waddr = top_q + PTR_W'(1);
              top_d     = top_q + PTR_W'(1);
              if (!ras_full) begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
        end
      end

      HALT: begin
        if (bus.trap_i) begin
          state_d = RUN;
          pc_d    = TRAP_VEC;
          cnt_d   = '0;
        end else if (bus.start_i) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  assign bus.pc_o        = pc_q;
  assign bus.pc_valid_o  = (state_q == RUN);
  assign bus.ras_empty_o = ras_empty;
  assign bus.ras_full_o  = ras_full;
  assign bus.state_o     = state_q;

endmodule
